// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Optional MDU_ZERO_SKIP_EN: zero-operand multiply/divide bypasses the 32-cycle loop.
`default_nettype none

module mdu_hilo (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      r_state, w_next;
  logic [4:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_opb, r_hi, r_lo;
  logic        r_div, r_sa, r_sb, r_dbz, r_zero, r_done, r_dbz_o;

  logic        w_signed, w_dbz, w_zskip;
  logic [31:0] w_abs_a, w_abs_b;

  assign w_signed = ~op[0];
  assign w_dbz    = op[1] && (b == 32'd0);
  assign w_abs_a  = (w_signed && a[31]) ? -a : a;
  assign w_abs_b  = (w_signed && b[31]) ? -b : b;

`ifdef MDU_ZERO_SKIP_EN
  assign w_zskip = op[1] ? ((a == 32'd0) && (b != 32'd0))
                         : ((a == 32'd0) || (b == 32'd0));
`else
  assign w_zskip = 1'b0;
`endif

  // Multiply: add multiplicand into the upper half when LSB set, then shift right.
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_step;
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
  assign w_mul_step = {w_mul_sum, r_acc[31:1]};

  // Divide: restoring step; upper half is partial remainder, lower half shifts in quotient.
  logic [32:0] w_rs;
  logic        w_ge;
  logic [31:0] w_rdiff;
  logic [63:0] w_div_step;
  assign w_rs       = {r_acc[63:32], r_acc[31]};
  assign w_ge       = (w_rs >= {1'b0, r_opb});
  assign w_rdiff    = w_rs[31:0] - r_opb;
  assign w_div_step = {(w_ge ? w_rdiff : w_rs[31:0]), r_acc[30:0], w_ge};

  logic [63:0] w_prod;
  logic [31:0] w_quot, w_rem, w_hi_res, w_lo_res;
  assign w_prod   = (r_sa ^ r_sb) ? -r_acc : r_acc;
  assign w_quot   = (r_sa ^ r_sb) ? -r_acc[31:0] : r_acc[31:0];
  assign w_rem    = r_sa ? -r_acc[63:32] : r_acc[63:32];
  assign w_hi_res = r_div ? w_rem  : w_prod[63:32];
  assign w_lo_res = r_div ? w_quot : w_prod[31:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = (w_dbz || w_zskip) ? S_FIX : S_CALC;
      S_CALC: if (r_cnt == 5'd31) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= 5'd0;
      r_acc   <= 64'd0;
      r_opb   <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_div   <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_dbz   <= 1'b0;
      r_zero  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz_o <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_dbz_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mthi) r_hi <= wdata;
          if (mtlo) r_lo <= wdata;
          if (start) begin
            r_div  <= op[1];
            r_sa   <= w_signed & a[31];
            r_sb   <= w_signed & b[31];
            r_acc  <= {32'd0, w_abs_a};
            r_opb  <= w_abs_b;
            r_cnt  <= 5'd0;
            r_dbz  <= w_dbz;
            r_zero <= w_zskip;
          end
        end
        S_CALC: begin
          r_acc <= r_div ? w_div_step : w_mul_step;
          r_cnt <= r_cnt + 5'd1;
        end
        S_FIX: begin
          r_done  <= 1'b1;
          r_dbz_o <= r_dbz;
          if (r_zero) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
          end else if (!r_dbz) begin
            r_hi <= w_hi_res;
            r_lo <= w_lo_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz_o;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed vectors for mdu_hilo, checked with immediate assertions.
`default_nettype none

module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0, b = 32'd0, wdata = 32'd0;
  logic        mthi = 1'b0, mtlo = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int nvec = 0;
  int nfail = 0;
  int lat, nbusy;
  logic dbz_seen;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  mdu_hilo dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a start in the current cycle (cycle 0) and count cycles until done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb);
    op = o; a = va; b = vb; start = 1'b1;
    lat = 0; nbusy = 0; dbz_seen = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) nbusy++;
      if (div_by_zero && !done) dbz_seen = 1'b1;
      if (done) begin
        lat = k;
        dbz_seen = dbz_seen | div_by_zero;
        break;
      end
    end
    if (lat == 0) begin
      nvec++; nfail++;
      $error("FAIL timeout: observed no done expected done within 60 cycles");
    end
  endtask

  task automatic op_check(input string tag, input logic [1:0] o, input logic [31:0] va,
                          input logic [31:0] vb, input logic [31:0] ehi, input logic [31:0] elo);
    run_op(o, va, vb);
    check({tag, "_hi"}, hi, ehi);
    check({tag, "_lo"}, lo, elo);
    check({tag, "_lat"}, lat, 32'd34);
    check({tag, "_dbz"}, {31'd0, dbz_seen}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);
    check("multu_lat", lat, 32'd34);
    check("multu_busy", nbusy, 32'd33);
    @(negedge clk);
    check("done_low", {31'd0, done}, 32'd0);

    op_check("mult_neg", MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    op_check("mult_min", MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    op_check("div_neg", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    op_check("div_negb", DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    op_check("divu", DIVU, 32'h80000000, 32'd3, 32'h00000002, 32'h2AAAAAAA);
    op_check("divu_small", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    op_check("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // Move-to writes, singly and together.
    mthi = 1'b1; wdata = 32'h12345678;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi", hi, 32'h12345678);
    mtlo = 1'b1; wdata = 32'hCAFEF00D;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo", lo, 32'hCAFEF00D);
    check("mtlo_hi_kept", hi, 32'h12345678);

    run_op(DIV, 32'd9, 32'd0);
    check("dbz_lat", lat, 32'd2);
    check("dbz_flag", {31'd0, div_by_zero}, 32'd1);
    check("dbz_busy", nbusy, 32'd1);
    check("dbz_hi", hi, 32'h12345678);
    check("dbz_lo", lo, 32'hCAFEF00D);
    @(negedge clk);
    check("dbz_low", {31'd0, div_by_zero}, 32'd0);

    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0F0F0F0F;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    check("mtboth_hi", hi, 32'h0F0F0F0F);
    check("mtboth_lo", lo, 32'h0F0F0F0F);

    // mthi on the same edge as start, then overwritten by the result.
    mthi = 1'b1; wdata = 32'h55555555; op = MULTU; a = 32'd2; b = 32'd3; start = 1'b1;
    @(negedge clk);
    mthi = 1'b0; start = 1'b0;
    check("same_edge_mthi", hi, 32'h55555555);
    for (int k = 0; k < 40 && !done; k++) @(negedge clk);
    check("same_edge_hi", hi, 32'd0);
    check("same_edge_lo", lo, 32'd6);

    // Second start and mtlo while busy are ignored; reset mid-operation.
    @(negedge clk);
    op = MULT; a = 32'd3; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    op = DIVU; a = 32'd1; b = 32'd0; start = 1'b1; mtlo = 1'b1; wdata = 32'hAAAA5555;
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0;
    check("busy_mtlo", lo, 32'd6);
    repeat (3) @(negedge clk);
    check("busy_ignored", {30'd0, busy, done}, 32'd2);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_hi", hi, 32'd0);
    check("mid_rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_done", {31'd0, done}, 32'd0);

    op_check("post_rst", MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1);

    run_op(MULT, 32'd0, 32'd5);
    check("zero_hi", hi, 32'd0);
    check("zero_lo", lo, 32'd0);
`ifdef MDU_ZERO_SKIP_EN
    check("zero_lat", lat, 32'd2);
`else
    check("zero_lat", lat, 32'd34);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
